// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles when others are waiting.
module rr_mux_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] data_in,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       data_out,
   output logic       data_valid
);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic       busy_q, busy_d;
   logic       dout_q, dout_d;
   logic       dvalid_q, dvalid_d;
   logic       do_grant;
   logic [1:0] win;

   // Parameter legality is checked at elaboration; an illegal set elaborates this empty block.
   if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_hold_params
   end

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
`endif

   // First requester at or after p (mod 4); scanning downward lets the nearest one win.
   function automatic logic [1:0] find_winner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] idx;
      w = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) w = idx;
      end
      return w;
   endfunction

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      ptr_d    = ptr_q;
      busy_d   = busy_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      do_grant = 1'b0;
      win      = 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold_d   = hold_q;
`endif
      case (state_q)
         StIdle: begin
            if (|req) do_grant = 1'b1;
         end
         StGrant: begin
            if (req[sel_q]) begin
               dout_d   = data_in[sel_q];
               dvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               if (hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
               if (hold_q == HOLD_W'(MAX_HOLD - 1) && |(req & ~gnt_q)) begin
                  ptr_d    = sel_q + 2'd1;
                  do_grant = 1'b1;
               end
`endif
            end else begin
               ptr_d = sel_q + 2'd1;
               if (|req) begin
                  do_grant = 1'b1;
               end else begin
                  state_d = StIdle;
                  gnt_d   = 4'b0000;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Search always starts from the updated pointer so a releasing owner ranks last.
      if (do_grant) begin
         win     = find_winner(req, ptr_d);
         state_d = StGrant;
         gnt_d   = 4'b0001 << win;
         sel_d   = win;
         busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
         hold_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         gnt_q    <= 4'b0000;
         sel_q    <= 2'd0;
         ptr_q    <= 2'd0;
         busy_q   <= 1'b0;
         dout_q   <= 1'b0;
         dvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         sel_q    <= sel_d;
         ptr_q    <= ptr_d;
         busy_q   <= busy_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= hold_d;
   end
`endif

   assign gnt        = gnt_q;
   assign sel        = sel_q;
   assign busy       = busy_q;
   assign data_out   = dout_q;
   assign data_valid = dvalid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table plus multi-cycle sequences,
// expected outputs queued when inputs are driven and compared after the clock edge.
module tb_rr_mux_arbiter;

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       dv;
      logic       dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] data_in;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       data_out;
   logic       data_valid;

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t sb_q[$];
   vec_t tbl[23];

   rr_mux_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .data_in    (data_in),
      .gnt        (gnt),
      .sel        (sel),
      .busy       (busy),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                               input logic [1:0] s, input logic b, input logic v,
                               input logic o);
      vec_t x;
      x.req = r; x.din = d; x.gnt = g; x.sel = s; x.busy = b; x.dv = v; x.dout = o;
      return x;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
   endtask

   // Drive inputs mid-cycle, queue the expected post-edge outputs, compare just after the edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      req     = v.req;
      data_in = v.din;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, ".gnt"},  gnt,                 e.gnt);
         check({tag, ".sel"},  {2'b00, sel},        {2'b00, e.sel});
         check({tag, ".busy"}, {3'b000, busy},      {3'b000, e.busy});
         check({tag, ".dv"},   {3'b000, data_valid}, {3'b000, e.dv});
         check({tag, ".dout"}, {3'b000, data_out},  {3'b000, e.dout});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".gnt"},  gnt,                  4'b0000);
      check({tag, ".sel"},  {2'b00, sel},         4'b0000);
      check({tag, ".busy"}, {3'b000, busy},       4'b0000);
      check({tag, ".dv"},   {3'b000, data_valid}, 4'b0000);
      check({tag, ".dout"}, {3'b000, data_out},   4'b0000);
   endtask

   initial begin
      //             req      din      gnt      sel busy dv  dout
      // full rotation with no idle gaps
      tbl[0]  = mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, 0);
      tbl[1]  = mk(4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1, 1);
      tbl[2]  = mk(4'b1110, 4'b0000, 4'b0010, 2'd1, 1, 0, 1);
      tbl[3]  = mk(4'b1100, 4'b0000, 4'b0100, 2'd2, 1, 0, 1);
      tbl[4]  = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0, 1);
      tbl[5]  = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 1, 0);
      tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0, 0);
      // data_in[2] streaming 1,0,1 then release holds the last bit
      tbl[7]  = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0, 0);
      tbl[8]  = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1);
      tbl[9]  = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 1, 0);
      tbl[10] = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1);
      tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 1);
      // bring ptr back to 0 via requester 3 (wrap-around)
      tbl[12] = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0, 1);
      tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0, 1);
      // fairness between 0 and 3
      tbl[14] = mk(4'b1001, 4'b0000, 4'b0001, 2'd0, 1, 0, 1);
      tbl[15] = mk(4'b1001, 4'b1001, 4'b0001, 2'd0, 1, 1, 1);
      tbl[16] = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0, 1);
      tbl[17] = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 1, 0);
      tbl[18] = mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 0, 0);
      tbl[19] = mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, 1);
      // no preemption while owner keeps requesting
      tbl[20] = mk(4'b0111, 4'b0000, 4'b0001, 2'd0, 1, 1, 0);
      tbl[21] = mk(4'b0110, 4'b0000, 4'b0010, 2'd1, 1, 0, 0);
      tbl[22] = mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);

      rst_n   = 1'b0;
      req     = 4'b0000;
      data_in = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // asynchronous reset in the middle of a grant to requester 2 (ptr is 2 here)
      apply(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0), "pre_rst0");
      apply(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 1, 0), "pre_rst1");
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      rst_n = 1'b1;
      apply(mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0), "post_rst");
      apply(mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0), "post_rst_rel");

      // req=0011 held from ptr=3
      apply(mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0, 0), "hold_first");
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 7; i++)
         apply(mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 1, 0), $sformatf("to_g0_%0d", i));
      for (int i = 0; i < 8; i++)
         apply(mk(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 1, 0), $sformatf("to_g1_%0d", i));
      apply(mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 1, 0), "to_back0");
      apply(mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0), "to_rel");
      // lone requester keeps its grant past the timeout
      apply(mk(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0), "solo_first");
      for (int i = 0; i < 24; i++)
         apply(mk(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 1, 0), $sformatf("solo_%0d", i));
`else
      for (int i = 0; i < 24; i++)
         apply(mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 1, 0), $sformatf("no_to_%0d", i));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux datapath between four requesters.
- Issues a one-hot grant (decoder2_4 style) and a 2-bit select (mux4_1 style).
- Registers the selected requester's data bit into a single output with a valid flag.
- Sits between lab requester logic and the shared mux/decoder datapath; it is the only sequencer of that datapath.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per requester when ARB_TIMEOUT_EN is defined; legal range 2..15.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; req[i] is held high for as long as requester i wants the datapath.
- data_in  input  4  data bit per requester; data_in[i] belongs to requester i.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  binary index of the granted requester; drives the shared mux select.
- busy  output  1  high while any grant is active.
- data_out  output  1  registered data_in[sel].
- data_valid  output  1  data_out holds a bit captured during a granted cycle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - gnt=0000, sel=00, busy=0, data_out=0, data_valid=0.
  - Internal priority pointer ptr=0, hold counter=0, state IDLE.
  - Assertion mid-grant clears everything immediately, with no clock edge needed.
- States: IDLE, GRANT.
- Winner search: the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge: GRANT, gnt[w]=1, sel=w, busy=1, hold counter=0.
  - Latency is 1 cycle from req rising to gnt.
- GRANT with req[sel]=1:
  - Hold the grant; increment the hold counter, saturating at MAX_HOLD.
  - At each such edge, data_out<=data_in[sel] and data_valid<=1.
- GRANT with req[sel]=0 (release):
  - At the edge, ptr<=sel+1 mod 4 and data_valid<=0.
  - If any other req is high, grant moves directly to the winner searched from the new ptr, with no idle gap.
  - Otherwise go to IDLE: gnt=0, busy=0, sel holds its last value.
- Data rules:
  - data_out holds its last value when data_valid=0.
  - data_valid is never high in a cycle whose preceding edge had no granted, requesting owner.
- Invariants: gnt is always one-hot or zero. When busy=1, sel equals the index of the set gnt bit.
- Requests from non-granted requesters are ignored until release; there is no preemption (except timeout, below).
- Grant order: a requester that just released is lowest priority on the next search.
- Glitch rule: a request that drops and re-rises while not granted carries no memory; requests are level-only.
- Wrap-around: when ptr=3, sel=3 releases and ptr becomes 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Forced release applies when the hold counter reaches MAX_HOLD-1 while req[sel]=1 and any other req is high.
  - On the next edge, ptr<=sel+1 mod 4 and the grant moves to the new winner; data is captured as a normal granted cycle.
  - If no other requester is pending, the counter saturates and the grant is kept.
  - The counter resets to 0 on every new grant.
- Undefined:
  - The counter logic is absent and grants are held indefinitely.
  - HOLD_W and MAX_HOLD are unused.

Test Plan:
1. Reset, then req=1111 held: gnt=0001 one cycle after req. Release req[0]: gnt 0010, then 0100, then 1000 on successive releases, each with no idle cycle. Finally req=0000 gives gnt=0000, busy=0.
2. req=0100 with data_in[2] toggling 1,0,1: sel=10, data_out follows 1,0,1 one cycle delayed, data_valid=1 throughout. Dropping req[2]: data_valid=0 next edge, data_out holds its last value.
3. Fairness: req=1001 while ptr=0 gives gnt=0001. After release with req[3] still high, gnt=1000. After that release, with req=0001 re-raised, gnt=0001 (wrap from ptr 0 again, i.e. 3+1 mod 4).
4. Assert rst_n=0 between clock edges during gnt=0100: all outputs are 0 immediately. Deassert with req=0100: gnt=0100 one cycle after the first edge.
5. ARB_TIMEOUT_EN, MAX_HOLD=8, req=0011 held: gnt=0001 for exactly 8 cycles, then 0010 for 8, then 0001.
6. ARB_TIMEOUT_EN with only req[0] held: gnt=0001 remains high for more than 20 cycles.
7. Macro undefined, req=0011 held: gnt=0001 for more than 20 cycles, never switching.
